// File: rtl/vga_sync_controller_if.sv
// Signal bundle between the VGA sync controller, the horizontal counter,
// the display control logic and the pixel generator / connector pins.
interface vga_sync_controller_if;
    logic [10:0] cntHorizontal;
    logic        line_tick;
    logic        start;
    logic        stop;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pix_tick;
    logic        frame_start;
    logic        running;
    logic [9:0]  vcount;

    modport master (
        input  cntHorizontal, line_tick, start, stop,
        output hsync, vsync, video_on, pixel_x, pixel_y,
               pix_tick, frame_start, running, vcount
    );

    modport slave (
        output cntHorizontal, line_tick, start, stop,
        input  hsync, vsync, video_on, pixel_x, pixel_y,
               pix_tick, frame_start, running, vcount
    );
endinterface

// File: rtl/vga_sync_controller.sv
// VGA raster sequencer: vertical line counter, sync/video generation and a
// start/stop FSM that only switches the display on whole-frame boundaries.
module vga_sync_controller #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_PER_PIX = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    vga_sync_controller_if.master bus
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIX_SHIFT = (CLK_PER_PIX == 4) ? 2 : (CLK_PER_PIX == 2) ? 1 : 0;

    localparam logic [10:0] H_COUNT_END = 11'(H_TOTAL * CLK_PER_PIX);
    localparam logic [10:0] H_VIS_END   = 11'(H_ACTIVE);
    localparam logic [10:0] HS_FIRST    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] PIX_MASK    = 11'(CLK_PER_PIX - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_END   = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_FIRST    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [9:0]  vcount_q, vcount_nxt;
    logic [10:0] h_pix;
    logic        frame_end, h_valid, showing;
    logic        hsync_d, vsync_d, video_d, pix_tick_d, frame_start_d;
    logic [9:0]  pixel_x_d, pixel_y_d;

    logic        hsync_q, vsync_q, video_q, pix_tick_q, frame_start_q, running_q;
    logic [9:0]  pixel_x_q, pixel_y_q;

    assign h_pix     = bus.cntHorizontal >> PIX_SHIFT;
    assign h_valid   = bus.cntHorizontal < H_COUNT_END;
    assign frame_end = bus.line_tick && (vcount_q == V_LAST);

    always_comb begin
        vcount_nxt = vcount_q;
        if (bus.line_tick)
            vcount_nxt = frame_end ? 10'd0 : vcount_q + 10'd1;
    end

    // Stop has priority in ARMED/RUN, start has priority in IDLE/DRAIN.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ARMED;
            ARMED:   if (bus.stop) state_nxt = IDLE;
                     else if (frame_end) state_nxt = RUN;
            RUN:     if (bus.stop) state_nxt = DRAIN;
            DRAIN:   if (bus.start) state_nxt = RUN;
                     else if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are built from the line and state in effect after this edge, so the
    // pins stay coherent with vcount/running in the same cycle.
    always_comb begin
        showing       = (state_nxt == RUN) || (state_nxt == DRAIN);
        hsync_d       = !(showing && h_valid && (h_pix >= HS_FIRST) && (h_pix <= HS_LAST));
        vsync_d       = !(showing && h_valid && (vcount_nxt >= VS_FIRST) && (vcount_nxt <= VS_LAST));
        video_d       = showing && h_valid && (h_pix < H_VIS_END) && (vcount_nxt < V_VIS_END);
        pixel_x_d     = video_d ? h_pix[9:0] : 10'd0;
        pixel_y_d     = video_d ? vcount_nxt : 10'd0;
        pix_tick_d    = (bus.cntHorizontal & PIX_MASK) == 11'd0;
        frame_start_d = frame_end && showing;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            vcount_q      <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_q       <= 1'b0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 10'd0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state         <= state_nxt;
            vcount_q      <= vcount_nxt;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_q       <= video_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
            running_q     <= showing;
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.video_on    = video_q;
    assign bus.pixel_x     = pixel_x_q;
    assign bus.pixel_y     = pixel_y_q;
    assign bus.pix_tick    = pix_tick_q;
    assign bus.frame_start = frame_start_q;
    assign bus.running     = running_q;
    assign bus.vcount      = vcount_q;
endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed bench for vga_sync_controller; lines are fast-forwarded by pulsing
// line_tick with cntHorizontal=0, followed by one clock at count 1.
`timescale 1ns/1ps
module tb_vga_sync_controller;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    int vs_low, vs_min, vs_max, vid_n, vid_bad, fs_n, not_run;

    vga_sync_controller_if bus ();

    vga_sync_controller dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic step(input logic [10:0] cnt, input logic lt);
        bus.cntHorizontal = cnt;
        bus.line_tick     = lt;
        tick();
    endtask

    task automatic clear_stats();
        vs_low = 0; vs_min = 1023; vs_max = 0;
        vid_n = 0; vid_bad = 0; fs_n = 0; not_run = 0;
    endtask

    task automatic sample();
        if (!bus.vsync) begin
            vs_low++;
            if (int'(bus.vcount) < vs_min) vs_min = int'(bus.vcount);
            if (int'(bus.vcount) > vs_max) vs_max = int'(bus.vcount);
        end
        if (bus.video_on) begin
            vid_n++;
            if (bus.vcount >= 10'd480) vid_bad++;
        end
        if (bus.frame_start) fs_n++;
        if (!bus.running) not_run++;
    endtask

    task automatic adv_lines(input int n);
        for (int i = 0; i < n; i++) begin
            step(11'd0, 1'b1); sample();
            step(11'd1, 1'b0); sample();
        end
    endtask

    task automatic req(input logic s, input logic p, input logic [10:0] cnt);
        bus.start = s;
        bus.stop  = p;
        step(cnt, 1'b0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        int hs_n, pt_n, px_inc, first_hs, last_hs, first_off;
        logic [9:0] prev_px;

        bus.cntHorizontal = 11'd0;
        bus.line_tick     = 1'b0;
        bus.start         = 1'b0;
        bus.stop          = 1'b0;
        clear_stats();

        // Reset values
        #23;
        check("rst_hsync", bus.hsync, 1);
        check("rst_vsync", bus.vsync, 1);
        check("rst_video", bus.video_on, 0);
        check("rst_vcount", bus.vcount, 0);
        check("rst_running", bus.running, 0);
        check("rst_pix_tick", bus.pix_tick, 0);
        check("rst_frame_start", bus.frame_start, 0);
        tick();
        Reset = 1'b1;
        step(11'd4, 1'b0);
        check("idle_pix_tick_even", bus.pix_tick, 1);
        step(11'd5, 1'b0);
        check("idle_pix_tick_odd", bus.pix_tick, 0);

        // Start at line 100 -> ARMED, no sync or video until the frame boundary
        clear_stats();
        adv_lines(100);
        check("vcount_100", bus.vcount, 100);
        req(1'b1, 1'b0, 11'd5);
        check("armed_running", bus.running, 0);
        step(11'd1320, 1'b0);
        check("armed_hsync", bus.hsync, 1);
        clear_stats();
        adv_lines(424);
        check("armed_vcount_524", bus.vcount, 524);
        check("armed_vs_low", vs_low, 0);
        check("armed_video", vid_n, 0);
        check("armed_fs", fs_n, 0);
        step(11'd0, 1'b1);
        check("enter_fs", bus.frame_start, 1);
        check("enter_vcount", bus.vcount, 0);
        check("enter_running", bus.running, 1);
        check("enter_video", bus.video_on, 1);
        step(11'd1, 1'b0);
        check("enter_fs_one_clk", bus.frame_start, 0);

        // Horizontal sweep of line 1 in RUN
        hs_n = 0; pt_n = 0; px_inc = 0; first_hs = -1; last_hs = -1; first_off = -1;
        clear_stats();
        prev_px = 10'd0;
        for (int c = 0; c < 1600; c++) begin
            step(11'(c), c == 0);
            sample();
            if (!bus.hsync) begin
                hs_n++;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            if (bus.pix_tick) pt_n++;
            if (bus.video_on && c > 0 && bus.pixel_x == prev_px + 10'd1) px_inc++;
            if (!bus.video_on && first_off < 0) first_off = c;
            prev_px = bus.pixel_x;
            if (c == 1278) check("px_at_1278", bus.pixel_x, 639);
            if (c == 700) check("py_line1", bus.pixel_y, 1);
        end
        check("sweep_video_n", vid_n, 1280);
        check("sweep_first_off", first_off, 1280);
        check("sweep_hs_n", hs_n, 192);
        check("sweep_first_hs", first_hs, 1312);
        check("sweep_last_hs", last_hs, 1503);
        check("sweep_pix_ticks", pt_n, 800);
        check("sweep_px_inc", px_inc, 639);
        check("blank_px_zero", bus.pixel_x, 0);

        // Full frame in RUN
        clear_stats();
        adv_lines(523);
        check("run_vcount_524", bus.vcount, 524);
        check("run_fs_early", fs_n, 0);
        adv_lines(1);
        check("run_fs_first", fs_n, 1);
        clear_stats();
        adv_lines(524);
        check("run_fs_gap", fs_n, 0);
        adv_lines(1);
        check("run_fs_525", fs_n, 1);
        check("frame_vs_low", vs_low, 4);
        check("frame_vs_min", vs_min, 490);
        check("frame_vs_max", vs_max, 491);
        check("frame_video_bad", vid_bad, 0);
        check("frame_video_n", vid_n, 960);

        // Out-of-range horizontal count on a vsync line
        adv_lines(490);
        step(11'd1700, 1'b0);
        check("oor_vsync", bus.vsync, 1);
        check("oor_hsync", bus.hsync, 1);
        check("oor_video", bus.video_on, 0);
        step(11'd1400, 1'b0);
        check("inr_vsync", bus.vsync, 0);
        check("inr_hsync", bus.hsync, 0);
        adv_lines(35);
        check("wrap_vcount", bus.vcount, 0);

        // Stop at 200 -> DRAIN until end of frame, then IDLE
        adv_lines(200);
        req(1'b0, 1'b1, 11'd2);
        check("drain_running", bus.running, 1);
        check("drain_video", bus.video_on, 1);
        check("drain_py", bus.pixel_y, 200);
        clear_stats();
        adv_lines(324);
        check("drain_vs_low", vs_low, 4);
        check("drain_not_run", not_run, 0);
        adv_lines(1);
        check("drain_to_idle", bus.running, 0);
        check("drain_no_fs", bus.frame_start, 0);
        clear_stats();
        adv_lines(495);
        check("idle_vs_low", vs_low, 0);
        check("idle_video", vid_n, 0);
        step(11'd1320, 1'b0);
        check("idle_hsync", bus.hsync, 1);

        // Start during DRAIN cancels the stop
        req(1'b1, 1'b0, 11'd5);
        adv_lines(30);
        check("rearm_running", bus.running, 1);
        adv_lines(200);
        req(1'b0, 1'b1, 11'd2);
        adv_lines(100);
        check("cancel_vcount", bus.vcount, 300);
        req(1'b1, 1'b0, 11'd3);
        clear_stats();
        adv_lines(225);
        check("cancel_running", bus.running, 1);
        check("cancel_not_run", not_run, 0);
        check("cancel_fs", fs_n, 1);
        check("cancel_vs_low", vs_low, 4);

        // Simultaneous start/stop: stop wins in RUN
        req(1'b1, 1'b1, 11'd5);
        check("both_run_running", bus.running, 1);
        adv_lines(525);
        check("both_run_drained", bus.running, 0);

        // Stop wins in ARMED, start wins in IDLE
        req(1'b1, 1'b0, 11'd5);
        req(1'b1, 1'b1, 11'd5);
        clear_stats();
        adv_lines(525);
        check("both_armed_idle", bus.running, 0);
        check("both_armed_fs", fs_n, 0);
        req(1'b1, 1'b1, 11'd5);
        clear_stats();
        adv_lines(525);
        check("both_idle_run", bus.running, 1);
        check("both_idle_fs", fs_n, 1);

        // Asynchronous reset mid-RUN at line 300
        adv_lines(300);
        step(11'd1320, 1'b0);
        check("pre_rst_vcount", bus.vcount, 300);
        check("pre_rst_hsync", bus.hsync, 0);
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_hsync", bus.hsync, 1);
        check("mid_rst_vsync", bus.vsync, 1);
        check("mid_rst_video", bus.video_on, 0);
        check("mid_rst_vcount", bus.vcount, 0);
        check("mid_rst_running", bus.running, 0);
        tick();
        Reset = 1'b1;
        step(11'd5, 1'b0);
        check("post_rst_vcount", bus.vcount, 0);
        clear_stats();
        adv_lines(525);
        check("post_rst_idle", bus.running, 0);
        check("post_rst_video", vid_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_controller.md
Name: vga_sync_controller

Overview:
Sequences the VGA raster around the free-running 11-bit horizontal counter (0..1599, two clocks per pixel, line-wrap flag asserted for one cycle while the count reads 0). Owns the vertical line counter and derives hsync, vsync, video_on, pixel coordinates and the pixel strobe. A start/stop state machine gates the display so that it is enabled and disabled only on whole-frame boundaries. Outputs feed the pixel generator and the VGA connector pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, hsync pulse width in pixels
H_BP, 48, horizontal back porch in pixels; H_TOTAL = sum = 800
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch in lines; V_TOTAL = sum = 525
CLK_PER_PIX, 2, clocks per pixel; legal values 1, 2, 4; H_TOTAL*CLK_PER_PIX must equal the horizontal counter modulus (1600)

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-low reset
cntHorizontal  input  11  horizontal clock count, 0..1599
line_tick  input  1  one-cycle pulse, high while cntHorizontal==0 after a wrap
start  input  1  level/pulse request to enable display
stop  input  1  level/pulse request to disable display
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
video_on  output  1  high inside the visible region while displaying
pixel_x  output  10  current pixel column, 0 when video_on low
pixel_y  output  10  current line, 0 when video_on low
pix_tick  output  1  one-cycle strobe at the first clock of each pixel
frame_start  output  1  one-cycle pulse on the first clock of a displayed frame
running  output  1  high in RUN and DRAIN
vcount  output  10  vertical line counter, 0..V_TOTAL-1

Behaviour:
- Reset low (asynchronous): state=IDLE, vcount=0, hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, pix_tick=0, frame_start=0, running=0.
- h_pix = cntHorizontal / CLK_PER_PIX (shift). All outputs are registered, with 1-cycle latency from cntHorizontal/vcount to pins.
- vcount: increments on line_tick and wraps from V_TOTAL-1 to 0. Counts in every state, so sync alignment is never lost. Frame boundary = line_tick while vcount==V_TOTAL-1.
- hsync low iff displaying and H_ACTIVE+H_FP <= h_pix <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
- vsync low iff displaying and V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
- video_on = displaying and h_pix < H_ACTIVE and vcount < V_ACTIVE. pixel_x = h_pix and pixel_y = vcount when video_on, else 0.
- pix_tick = registered (cntHorizontal mod CLK_PER_PIX == 0). It runs in all states except reset.
- cntHorizontal >= 1600 (out of range): treat as blanking. No sync and no video for that count.
- "displaying" means state is RUN or DRAIN.
- FSM states:
  - IDLE: sync pins high, video off. start -> ARMED.
  - ARMED: sync still off. At a frame boundary -> RUN, and frame_start pulses on the first cycle of RUN. stop in ARMED -> IDLE.
  - RUN: normal operation. stop -> DRAIN. frame_start pulses at every frame boundary.
  - DRAIN: keeps displaying until the frame boundary, then -> IDLE. start in DRAIN -> RUN (cancels the stop); the frame continues unbroken.
- Simultaneous start and stop: start wins in IDLE and DRAIN, stop wins in ARMED and RUN.
- Reset asserted mid-frame: immediate return to reset values. After release, vcount restarts at 0, and the first complete frame is displayed only after a new start and a frame boundary.

Test Plan:
- Reset low mid-RUN at vcount=300 -> next sample shows hsync=1, vsync=1, video_on=0, vcount=0, running=0, with no Clk edge required.
- Start asserted at vcount=100 -> state ARMED. On the line_tick with vcount=524, vcount goes to 0, RUN is entered, and frame_start pulses for exactly one clock; no sync pulses appear before that.
- In RUN, sweep cntHorizontal 0..1599 -> video_on for counts 0..1279, hsync low for counts 1312..1503 (one cycle later at pins), pix_tick on every even count, and pixel_x increments every 2 clocks (639 at count 1278).
- In RUN, run a full frame -> vsync low exactly on lines 490 and 491, video_on never high for vcount >= 480, and 525 line_ticks between frame_start pulses.
- Stop at vcount=200 -> DRAIN, display continues through line 524, then IDLE with sync pins held high. A start issued at vcount=300 during DRAIN instead keeps RUN with no glitch.
- Start and stop high together in IDLE -> ARMED; together in RUN -> DRAIN. cntHorizontal forced to 1700 -> video_on=0 and hsync=1.
